// File: rtl/serial_parity_pkg.sv
// rtl/serial_parity_pkg.sv - shared types and constants for the parity-protected serial link
//
// Holds the receiver state encoding, the default word width and the idle
// level of the serial line. Imported by serial_parity_rx.

package serial_parity_pkg;

    // Receiver frame states: waiting for a start bit, collecting data bits,
    // sampling the parity bit, sampling the stop bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Default number of data bits per frame.
    localparam int DEFAULT_DATA_W = 8;

    // The line rests high between frames; a low sample in IDLE is a start bit.
    localparam logic LINE_IDLE = 1'b1;

endpackage : serial_parity_pkg

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - 1-bit XOR parity accumulator with synchronous clear and enable
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears acc
//   clr    in   synchronous clear; wins over en
//   en     in   fold d into the running XOR this cycle
//   d      in   bit to accumulate
//   acc    out  running XOR of every d accepted since the last clear

module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule : parity_acc

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - bit-serial frame receiver with XOR parity and stop-bit checking
//
// Frame on rx_in, one bit per bit_en strobe:
//   start (0), DATA_W data bits LSB first, parity bit, stop bit (1).
//
// Parameters:
//   DATA_W      data bits per frame (2..16)
//   ODD_PARITY  0: data ^ parity must be 0; 1: data ^ parity must be 1
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   bit_en      in   one-cycle sample strobe per bit time
//   rx_in       in   serial line, idles high
//   data_out    out  last received word, held until the next frame completes
//   data_valid  out  one-cycle pulse per completed frame (errors included)
//   parity_err  out  parity result of the last frame
//   frame_err   out  stop bit of the last frame was sampled low
//   busy        out  frame in progress

module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    // Counter value while the final data bit is being sampled.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              perr_q,  perr_d;
    logic              ferr_q,  ferr_d;
    logic              busy_q,  busy_d;

    logic acc_clr;
    logic acc_en;
    logic acc;

    // Running XOR over the data bits and the parity bit of the current frame.
    parity_acc u_parity_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (rx_in),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;

        // Nothing advances without a strobe; every register holds its value.
        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_in != LINE_IDLE) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit lands at bit 0.
                    shift_d = {rx_in, shift_q[DATA_W-1:1]};
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    acc_en  = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    data_d  = shift_q;
                    perr_d  = acc ^ ODD_PARITY;
                    ferr_d  = ~rx_in;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered so busy drops in the same cycle data_valid rises.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule : serial_parity_rx

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - self-checking bench for serial_parity_rx (even and odd parity instances)

module tb_serial_parity_rx;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         bit_en = 1'b0;
    logic         rx_in  = 1'b1;

    logic [W-1:0] data_e, data_o;
    logic         dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

    serial_parity_rx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .rx_in      (rx_in),
        .data_out   (data_e),
        .data_valid (dv_e),
        .parity_err (pe_e),
        .frame_err  (fe_e),
        .busy       (busy_e)
    );

    serial_parity_rx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .rx_in      (rx_in),
        .data_out   (data_o),
        .data_valid (dv_o),
        .parity_err (pe_o),
        .frame_err  (fe_o),
        .busy       (busy_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int nv_e       = 0;
    int nv_o       = 0;

    // Reference model state: what each output should show after the last frame.
    logic [W-1:0] m_data = '0;
    logic         m_pe_e = 1'b0;
    logic         m_pe_o = 1'b0;
    logic         m_fe   = 1'b0;
    int           m_nv   = 0;
    int           valid_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dv_e === 1'b1) nv_e++;
        if (dv_o === 1'b1) nv_o++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs outside a data_valid cycle: no pulse, results held from the model.
    task automatic check_hold(input string tag, input logic exp_busy);
        check({tag, ".dv_e"},   dv_e,   32'd0);
        check({tag, ".dv_o"},   dv_o,   32'd0);
        check({tag, ".busy_e"}, busy_e, exp_busy);
        check({tag, ".busy_o"}, busy_o, exp_busy);
        check({tag, ".data_e"}, data_e, m_data);
        check({tag, ".data_o"}, data_o, m_data);
        check({tag, ".pe_e"},   pe_e,   m_pe_e);
        check({tag, ".pe_o"},   pe_o,   m_pe_o);
        check({tag, ".fe_e"},   fe_e,   m_fe);
        check({tag, ".fe_o"},   fe_o,   m_fe);
    endtask

    // One bit_en strobe carrying bit b; rx_in is scrambled afterwards since
    // it must be ignored while bit_en is low.
    task automatic strobe(input logic b);
        rx_in  = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        rx_in  = 1'($urandom);
    endtask

    task automatic gap_cycles(input string tag, input int n, input logic exp_busy);
        for (int g = 0; g < n; g++) begin
            @(posedge clk);
            #1;
            check_hold(tag, exp_busy);
        end
    endtask

    task automatic send_frame(input string tag, input logic [W-1:0] d,
                              input logic pbit, input logic sbit, input int gap);
        logic [W+2:0] bits;
        logic         ones;
        bits = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < W + 3; i++) begin
            strobe(bits[i]);
            if (i < W + 2) begin
                check_hold({tag, ".mid"}, 1'b1);
                gap_cycles({tag, ".gap"}, gap, 1'b1);
            end else begin
                ones   = ^{d, pbit};
                m_data = d;
                m_pe_e = ones;
                m_pe_o = ~ones;
                m_fe   = ~sbit;
                m_nv++;
                valid_cyc = cyc;
                check({tag, ".dv_e"},   dv_e,   32'd1);
                check({tag, ".dv_o"},   dv_o,   32'd1);
                check({tag, ".busy_e"}, busy_e, 32'd0);
                check({tag, ".busy_o"}, busy_o, 32'd0);
                check({tag, ".data_e"}, data_e, m_data);
                check({tag, ".data_o"}, data_o, m_data);
                check({tag, ".pe_e"},   pe_e,   m_pe_e);
                check({tag, ".pe_o"},   pe_o,   m_pe_o);
                check({tag, ".fe_e"},   fe_e,   m_fe);
                check({tag, ".fe_o"},   fe_o,   m_fe);
                gap_cycles({tag, ".post"}, gap, 1'b0);
            end
        end
    endtask

    // Line held idle (high) with random strobes: nothing may start.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            rx_in  = 1'b1;
            bit_en = 1'($urandom);
            @(posedge clk);
            #1;
            bit_en = 1'b0;
            check_hold("idle", 1'b0);
        end
    endtask

    initial begin
        int t0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_hold("reset", 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Good frame, then parity error on the same word
        send_frame("a5_ok",   8'hA5, 1'b0, 1'b1, 0);
        check("a5_ok.pe_e_zero", pe_e, 32'd0);
        send_frame("a5_perr", 8'hA5, 1'b1, 1'b1, 0);
        check("a5_perr.pe_e_one", pe_e, 32'd1);

        // Framing error, then an immediately following good frame
        send_frame("3c_ferr", 8'h3C, 1'b0, 1'b0, 0);
        check("3c_ferr.fe_e_one", fe_e, 32'd1);
        send_frame("81_after", 8'h81, 1'b0, 1'b1, 0);

        // Back-to-back frames, no idle gap
        send_frame("b2b_00", 8'h00, 1'b0, 1'b1, 0);
        t0 = valid_cyc;
        send_frame("b2b_ff", 8'hFF, 1'b0, 1'b1, 0);
        check("b2b.spacing", valid_cyc - t0, 32'd11);
        gap_cycles("b2b.tail", 1, 1'b0);

        // Sparse strobes: one bit_en every 4th cycle
        send_frame("5a_sparse", 8'h5A, 1'b0, 1'b1, 3);

        // Reset after the 4th data bit: partial word discarded
        strobe(1'b0);
        check_hold("abort.start", 1'b1);
        for (int i = 0; i < 4; i++) begin
            strobe(1'($urandom));
            check_hold("abort.bit", 1'b1);
        end
        rst_n = 1'b0;
        #1;
        m_data = '0;
        m_pe_e = 1'b0;
        m_pe_o = 1'b0;
        m_fe   = 1'b0;
        check_hold("abort.rst", 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_hold("abort.rel", 1'b0);
        check("abort.nv_e", nv_e, m_nv);
        send_frame("96_after_rst", 8'h96, 1'b1, 1'b1, 0);

        // Odd-parity pair (odd instance is the one under test here)
        send_frame("07_p0", 8'h07, 1'b0, 1'b1, 1);
        check("07_p0.pe_o_zero", pe_o, 32'd0);
        send_frame("07_p1", 8'h07, 1'b1, 1'b1, 0);
        check("07_p1.pe_o_one", pe_o, 32'd1);

        // Randomized frames against the model
        for (int n = 0; n < 24; n++) begin
            idle($urandom_range(0, 2));
            send_frame("rand", 8'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
        end
        gap_cycles("final", 2, 1'b0);

        check("count.nv_e", nv_e, m_nv);
        check("count.nv_o", nv_o, m_nv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_serial_parity_rx
